csc_mac_rgb: RTL and testbench

- Colour-space MAC stage that sits directly downstream of the sign/magnitude front end.
- Per pixel it consumes the unsigned Y/Xb/Xr magnitudes, the 12-bit add/subtract control word and the clamp thresholds.
- It evaluates the 3x3 conversion matrix with one time-shared multiplier and returns clamped 8-bit R, G, B values.
- Input and output each use a valid/ready handshake.

---
 rtl/csc_mac_rgb.sv | 158 +++++++++++++++
 tb/tb_csc_mac_rgb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csc_mac_rgb.sv
// Colour-space conversion MAC: evaluates a 3x3 Q2.8 matrix on Y/Xb/Xr magnitudes with a single
// time-shared multiplier and returns clamped 8-bit R, G, B behind valid/ready handshakes.
module csc_mac_rgb #(
  parameter logic [89:0] COEF = {10'd256, 10'd0,   10'd403,
                                 10'd256, 10'd48,  10'd120,
                                 10'd256, 10'd475, 10'd0},
  parameter bit          RND  = 1'b1
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  usign_y,
  input  logic [7:0]  usign_xb,
  input  logic [7:0]  usign_xr,
  input  logic [11:0] add_sub_ctr,
  input  logic [7:0]  thresh_low,
  input  logic [7:0]  thresh_hi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [7:0]         y_q, xb_q, xr_q, tlo_q, thi_q;
  logic [11:0]        ctr_q;
  logic signed [19:0] acc_q;
  logic [3:0]         idx_q;
  logic [1:0]         row_q, col_q;
  logic [7:0]         r_q, g_q, b_q;

  logic               accept;
  logic [9:0]         coef_tab [16];
  logic [9:0]         coef_sel;
  logic [7:0]         mag_sel;
  logic [3:0]         row_nib;
  logic               sub_sel;
  logic [17:0]        prod;
  logic signed [19:0] prod_s, sum, res, lo_s, hi_s, clamp_lo, clamp_hi;
  logic [7:0]         chan;

  // Flattened coefficient table indexed directly by idx (= 3*row + col).
  for (genvar i = 0; i < 9; i++) begin : g_coef
    assign coef_tab[i] = COEF[89-10*i -: 10];
  end
  for (genvar i = 9; i < 16; i++) begin : g_coef_pad
    assign coef_tab[i] = '0;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)        state_d = StCalc;
      StCalc:  if (idx_q == 4'd8)   state_d = StDone;
      StDone:  if (out_ready)       state_d = StIdle;
      default:                      state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state
  always_comb begin
    in_ready  = (state_q == StIdle) && !reset;
    out_valid = (state_q == StDone);
  end

  assign accept = in_valid && in_ready;

  // Datapath: one product per CALC cycle, folded into the row accumulator.
  always_comb begin
    coef_sel = coef_tab[idx_q];
    case (col_q)
      2'd0:    mag_sel = y_q;
      2'd1:    mag_sel = xb_q;
      default: mag_sel = xr_q;
    endcase
    case (row_q)
      2'd0:    row_nib = ctr_q[11:8];
      2'd1:    row_nib = ctr_q[7:4];
      default: row_nib = ctr_q[3:0];
    endcase
    case (col_q)
      2'd0:    sub_sel = row_nib[3];
      2'd1:    sub_sel = row_nib[2];
      default: sub_sel = row_nib[1];
    endcase
    prod     = {10'd0, mag_sel} * {8'd0, coef_sel};
    prod_s   = $signed({2'b00, prod});
    sum      = sub_sel ? (acc_q - prod_s) : (acc_q + prod_s);
    res      = (sum + (RND ? 20'sd128 : 20'sd0)) >>> 8;
    lo_s     = $signed({12'd0, tlo_q});
    hi_s     = $signed({12'd0, thi_q});
    // High threshold is applied last so it wins when the thresholds cross.
    clamp_lo = (res < lo_s) ? lo_s : res;
    clamp_hi = (clamp_lo > hi_s) ? hi_s : clamp_lo;
    chan     = clamp_hi[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      y_q   <= '0;
      xb_q  <= '0;
      xr_q  <= '0;
      tlo_q <= '0;
      thi_q <= '0;
      ctr_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      y_q   <= usign_y;
      xb_q  <= usign_xb;
      xr_q  <= usign_xr;
      tlo_q <= thresh_low;
      thi_q <= thresh_hi;
      ctr_q <= add_sub_ctr;
      acc_q <= '0;
      idx_q <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (state_q == StCalc) begin
      idx_q <= idx_q + 4'd1;
      if (col_q == 2'd2) begin
        col_q <= '0;
        row_q <= row_q + 2'd1;
        acc_q <= '0;
        case (row_q)
          2'd0:    r_q <= chan;
          2'd1:    g_q <= chan;
          default: b_q <= chan;
        endcase
      end else begin
        col_q <= col_q + 2'd1;
        acc_q <= sum;
      end
    end
  end

  assign out_r = r_q;
  assign out_g = g_q;
  assign out_b = b_q;

endmodule

// File: tb/tb_csc_mac_rgb.sv
// Directed bench for csc_mac_rgb: expected pixels go into a scoreboard queue on accept and are
// popped and compared when out_valid is observed.
module tb_csc_mac_rgb;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  usign_y, usign_xb, usign_xr;
  logic [11:0] add_sub_ctr;
  logic [7:0]  thresh_low, thresh_hi;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_r, out_g, out_b;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [23:0] sb[$];

  csc_mac_rgb dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .usign_y     (usign_y),
    .usign_xb    (usign_xb),
    .usign_xr    (usign_xr),
    .add_sub_ctr (add_sub_ctr),
    .thresh_low  (thresh_low),
    .thresh_hi   (thresh_hi),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_g       (out_g),
    .out_b       (out_b)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests_run++;
    assert (got === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
    end
  endtask

  // Reference model with the default coefficients and round half-up.
  function automatic logic [23:0] model(input int y, input int xb, input int xr,
                                        input logic [11:0] ctr, input int lo, input int hi);
    int coef[9];
    int mag[3];
    int acc, res, p;
    logic [7:0] ch[3];
    coef = '{256, 0, 403, 256, 48, 120, 256, 475, 0};
    mag  = '{y, xb, xr};
    for (int r = 0; r < 3; r++) begin
      acc = 0;
      for (int c = 0; c < 3; c++) begin
        p = mag[c] * coef[3*r+c];
        if (ctr[11-4*r-c]) acc = acc - p;
        else               acc = acc + p;
      end
      res = (acc + 128) >>> 8;
      if (res < lo) res = lo;
      if (res > hi) res = hi;
      ch[r] = res[7:0];
    end
    return {ch[0], ch[1], ch[2]};
  endfunction

  task automatic drive(input logic [7:0] y, input logic [7:0] xb, input logic [7:0] xr,
                       input logic [11:0] ctr, input logic [7:0] lo, input logic [7:0] hi);
    usign_y     = y;
    usign_xb    = xb;
    usign_xr    = xr;
    add_sub_ctr = ctr;
    thresh_low  = lo;
    thresh_hi   = hi;
    in_valid    = 1'b1;
  endtask

  // Returns just after the accepting edge.
  task automatic send(input logic [7:0] y, input logic [7:0] xb, input logic [7:0] xr,
                      input logic [11:0] ctr, input logic [7:0] lo, input logic [7:0] hi,
                      input logic [23:0] expv);
    int w;
    @(negedge clk_in);
    drive(y, xb, xr, ctr, lo, hi);
    w = 0;
    while (!in_ready && w < 40) begin
      @(negedge clk_in);
      w++;
    end
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk_in);
    sb.push_back(expv);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accepting edge; that edge counts as the first.
  task automatic wait_valid(input bit check_lat);
    int n;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("out_valid_seen", out_valid, 1);
    if (check_lat) chk("latency_edges", n, 10);
  endtask

  task automatic check_out(input string tag);
    logic [23:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_r"}, out_r, e[23:16]);
    chk({tag, "_g"}, out_g, e[15:8]);
    chk({tag, "_b"}, out_b, e[7:0]);
    @(negedge clk_in);
    out_ready = 1'b1;
    @(posedge clk_in);
    #1 out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    logic [23:0] held, nxt;
    logic [7:0]  ry, rxb, rxr;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(8'd0, 8'd0, 8'd0, 12'h000, 8'd0, 8'd255);
    in_valid = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_outs", {out_r, out_g, out_b}, 0);
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1 chk("post_rst_in_ready", in_ready, 1);

    // 1: luma only
    send(8'd100, 8'd0, 8'd0, 12'h060, 8'd0, 8'd255, {8'd100, 8'd100, 8'd100});
    wait_valid(1);
    check_out("t1");

    // 2: rounding
    send(8'd100, 8'd0, 8'd50, 12'h060, 8'd0, 8'd255, {8'd179, 8'd77, 8'd100});
    wait_valid(1);
    check_out("t2");

    // 3: upper clamp and subtract on R
    send(8'd255, 8'd0, 8'd127, 12'h060, 8'd0, 8'd255, {8'd255, 8'd195, 8'd255});
    wait_valid(0);
    check_out("t3a");
    send(8'd255, 8'd0, 8'd127, 12'h260, 8'd0, 8'd255, {8'd55, 8'd195, 8'd255});
    wait_valid(0);
    check_out("t3b");

    // 4: negative results and threshold handling
    send(8'd10, 8'd0, 8'd100, 12'h260, 8'd0, 8'd255, {8'd0, 8'd0, 8'd10});
    wait_valid(0);
    check_out("t4a");
    send(8'd10, 8'd0, 8'd100, 12'h260, 8'd16, 8'd255, {8'd16, 8'd16, 8'd16});
    wait_valid(0);
    check_out("t4b");
    send(8'd10, 8'd0, 8'd100, 12'h260, 8'd200, 8'd100, {8'd100, 8'd100, 8'd100});
    wait_valid(0);
    check_out("t4c");

    // 5: backpressure with a pending, changing input
    held = model(37, 200, 90, 12'h4a6, 5, 240);
    send(8'd37, 8'd200, 8'd90, 12'h4a6, 8'd5, 8'd240, held);
    wait_valid(1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      drive(8'($urandom), 8'($urandom), 8'($urandom), 12'($urandom), 8'd0, 8'd255);
      @(posedge clk_in);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_outs", {out_r, out_g, out_b}, held);
      chk("bp_in_ready", in_ready, 0);
    end
    void'(sb.pop_front());
    ry = 8'd200; rxb = 8'd31; rxr = 8'd77;
    @(negedge clk_in);
    drive(ry, rxb, rxr, 12'h2c4, 8'd10, 8'd230);
    nxt = model(ry, rxb, rxr, 12'h2c4, 10, 230);
    out_ready = 1'b1;
    @(posedge clk_in);
    #1 out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk_in);
    sb.push_back(nxt);
    #1 in_valid = 1'b0;
    chk("bp_accepted", in_ready, 0);
    wait_valid(1);
    check_out("t5");

    // 6: reset during CALC (idx 4)
    send(8'd100, 8'd0, 8'd50, 12'h060, 8'd0, 8'd255, {8'd179, 8'd77, 8'd100});
    repeat (4) @(posedge clk_in);
    @(negedge clk_in);
    reset = 1'b1;
    #1 chk("midrst_in_ready_now", in_ready, 0);
    @(posedge clk_in);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_outs", {out_r, out_g, out_b}, 0);
    chk("midrst_in_ready", in_ready, 0);
    void'(sb.pop_back());
    @(posedge clk_in);
    #1 chk("midrst_hold_in_ready", in_ready, 0);
    @(negedge clk_in);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    chk("midrst_release_valid", out_valid, 0);
    send(8'd100, 8'd0, 8'd50, 12'h060, 8'd0, 8'd255, {8'd179, 8'd77, 8'd100});
    wait_valid(1);
    check_out("t6");

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
